// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_seq_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // ceil(w * log10(2)) in integer arithmetic; log10(2) ~= 0.30103.
  function automatic int digits_for_width(int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 (wraps modulo 16).
module bcd_add3_digit
  import bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  always_comb begin
    if (digit >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      corrected = digit + BCD_DIGIT_W'(3);
    end else begin
      corrected = digit;
    end
  end

endmodule

// File: rtl/bcd_dabble_sequencer.sv
// Binary-to-BCD converter running one add-3/shift iteration per clock on a shared datapath.
// Optional leading-zero blanking enables (digit_en port) when BCD_SEQ_LZB_EN is defined.
module bcd_dabble_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          busy,
`ifdef BCD_SEQ_LZB_EN
  output logic [DIGITS-1:0]             digit_en,
`endif
  output bcd_seq_state_t                dbg_state
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 1) begin : g_bad_width
    $error("bcd_dabble_sequencer: BIN_W must be >= 1");
  end
  if (DIGITS < digits_for_width(BIN_W)) begin : g_bad_digits
    $error("bcd_dabble_sequencer: DIGITS too small for BIN_W");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is held with out_bcd stable until out_ready.

  bcd_seq_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [SCR_W-1:0]  scratch;
  logic [BCD_W-1:0]  digits_corr;
  logic [SCR_W-1:0]  corrected;
  logic [SCR_W-1:0]  shifted;
  logic [BCD_W-1:0]  shifted_bcd;
  logic              last_iter;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit     (scratch[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .corrected (digits_corr[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // Correction is applied to the digit field first, then the whole scratch shifts left.
  assign corrected   = {digits_corr, scratch[BIN_W-1:0]};
  assign shifted     = {corrected[SCR_W-2:0], 1'b0};
  assign shifted_bcd = shifted[SCR_W-1 -: BCD_W];
  assign last_iter   = (cnt == CNT_W'(BIN_W - 1));
  assign dbg_state   = state;

`ifdef BCD_SEQ_LZB_EN
  logic [DIGITS-1:0] digit_en_next;
  logic              lzb_seen;

  // A digit is shown if it or any more significant digit is nonzero; ones always shown.
  always_comb begin
    digit_en_next = '0;
    lzb_seen      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lzb_seen         = lzb_seen | (shifted_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W] != '0);
      digit_en_next[i] = lzb_seen;
    end
    digit_en_next[0] = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      scratch   <= '0;
`ifdef BCD_SEQ_LZB_EN
      digit_en  <= DIGITS'(1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            scratch  <= {{BCD_W{1'b0}}, in_bin};
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_bcd   <= shifted_bcd;
`ifdef BCD_SEQ_LZB_EN
            digit_en  <= digit_en_next;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
